mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative 32-bit unsigned multiply/divide unit for the pipeline CPU's EX stage. It sits alongside the combinational ALU and consumes the same 6-bit funct-code Signal bus. MULTU and DIVU run over 32 cycles into internal HI/LO registers. MFHI/MFLO read HI/LO back onto dataOut. The pipeline uses busy to stall while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
MULTU, 6'b011001, funct code 25: unsigned multiply
DIVU, 6'b011011, funct code 27: unsigned divide
MFHI, 6'b010000, funct code 16: read HI
MFLO, 6'b010010, funct code 18: read LO

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  issue strobe for the funct code on Signal
Signal  input  6  funct code
dataA  input  32  multiplicand / dividend
dataB  input  32  multiplier / divisor
dataOut  output  32  MFHI/MFLO read data
busy  output  1  operation in flight; pipeline must stall
done  output  1  one-cycle pulse when HI/LO are updated

Behaviour:
- Reset: asynchronous, active-high.
  - While reset=1: HI=LO=0, state IDLE, busy=0, done=0, dataOut=0 (forced combinationally).
  - Reset mid-operation aborts the operation. No partial result is written. Counter and working registers are cleared.
- States: IDLE, MUL, DIV, DONE.
- Accept rule: start=1 with Signal in {MULTU, DIVU} is sampled at edge k only when the state is IDLE or DONE.
  - At edge k: dataA/dataB are latched, count=0, state -> MUL or DIV.
  - start with any other Signal, or while in MUL/DIV, is ignored. There is no queueing.
- busy: 1 exactly in states MUL and DIV, i.e. the 32 cycles after edge k. Otherwise 0.
- MUL: shift-add over a 65-bit {carry, acc_hi, acc_lo}, one multiplier bit per edge, LSB first.
  - Iterations occur at edges k+1 .. k+32.
  - At edge k+32: {HI, LO} <= full 64-bit product, state -> DONE.
- DIV: restoring division, one quotient bit per edge, MSB first, over a 33-bit partial remainder.
  - At edge k+32: LO <= quotient, HI <= remainder, state -> DONE.
  - Divisor 0 needs no special path; the algorithm gives LO=32'hFFFFFFFF, HI=dividend. Latency is unchanged.
- DONE: lasts one cycle. done=1, busy=0.
  - Next edge: state -> IDLE, unless a new MULTU/DIVU is accepted (back-to-back allowed).
- Latency: done is high in cycle k+33 (counting from the accept edge). HI/LO hold new values from that cycle on.
- dataOut: combinational, when reset=0.
  - Signal=MFHI -> HI; Signal=MFLO -> LO; any other code -> 0.
  - Independent of start and busy. During MUL/DIV it shows the previous HI/LO; the pipeline is responsible for stalling MFHI/MFLO on busy.
- HI/LO change only at the completion edge or on reset.
- Arithmetic is unsigned only. No overflow or exception flags. Product is 64-bit exact.

Test Plan:
- Reset, start MULTU A=3, B=5 -> busy=1 for exactly 32 cycles; done pulses once in cycle k+33; HI=0, LO=0x0000000F; MFLO -> dataOut=0x0000000F, MFHI -> 0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU A=100, B=7 -> LO=14, HI=2; then DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678, same 32-cycle busy window.
- MULTU 6x7 issued, then start=1 with DIVU 9/3 during busy -> second request ignored; single done; LO=42. DIVU 9/3 issued during the DONE cycle -> accepted; busy rises next cycle; LO=3, HI=0 after 32 more cycles.
- Start MULTU 0x10000 x 0x10000, assert reset at iteration 10 -> busy, done and dataOut drop to 0 immediately; after release, MFHI/MFLO read 0; no done pulse occurs.
- Signal=ADD (6'b100000) with start=1 in IDLE -> no state change, busy stays 0, dataOut=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit for the EX stage.
// MULTU and DIVU each take WIDTH cycles and write the internal HI/LO pair.
// MFHI/MFLO read HI/LO back onto dataOut combinationally.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  // Multiplicand (MUL) or divisor (DIV), held for the whole operation.
  logic [WIDTH-1:0]    opa_q, opa_d;
  // MUL: {acc_hi, multiplier/acc_lo}.  DIV: low half holds dividend/quotient.
  logic [2*WIDTH-1:0]  work_q, work_d;
  // DIV partial remainder; one extra bit so the trial shift never overflows.
  logic [WIDTH:0]      rem_q, rem_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;

  logic                accept_s;
  logic [WIDTH:0]      mul_sum_s;
  logic [2*WIDTH-1:0]  mul_next_s;
  logic [WIDTH:0]      div_shift_s;
  logic                div_ge_s;
  logic [WIDTH:0]      div_rem_s;
  logic [WIDTH-1:0]    div_quo_s;

  // One datapath step: shift-add multiply bit (LSB first) and restoring divide bit (MSB first).
  always_comb begin
    mul_sum_s   = {1'b0, work_q[2*WIDTH-1:WIDTH]};
    if (work_q[0]) begin
      mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
    end else begin
      mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]};
    end
    // Right shift of the 65-bit {carry, acc_hi, acc_lo}, dropping the consumed multiplier bit.
    mul_next_s  = {mul_sum_s, work_q[WIDTH-1:1]};

    div_shift_s = {rem_q[WIDTH-1:0], work_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opa_q});
    if (div_ge_s) begin
      div_rem_s = div_shift_s - {1'b0, opa_q};
    end else begin
      div_rem_s = div_shift_s;
    end
    div_quo_s   = {work_q[WIDTH-2:0], div_ge_s};
  end

  // Next-state logic: accept new ops in IDLE/DONE, iterate in MUL/DIV, commit HI/LO on the last step.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    opa_d    = opa_q;
    work_d   = work_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    accept_s = start && ((Signal == MULTU) || (Signal == DIVU));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          count_d = {CW{1'b0}};
          rem_d   = {(WIDTH+1){1'b0}};
          if (Signal == MULTU) begin
            state_d = S_MUL;
            opa_d   = dataA;
            work_d  = {{WIDTH{1'b0}}, dataB};
          end else begin
            state_d = S_DIV;
            opa_d   = dataB;
            work_d  = {{WIDTH{1'b0}}, dataA};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        work_d  = mul_next_s;
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          hi_d    = mul_next_s[2*WIDTH-1:WIDTH];
          lo_d    = mul_next_s[WIDTH-1:0];
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        work_d  = {work_q[2*WIDTH-1:WIDTH], div_quo_s};
        rem_d   = div_rem_s;
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          hi_d    = div_rem_s[WIDTH-1:0];
          lo_d    = div_quo_s;
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= {CW{1'b0}};
      opa_q   <= {WIDTH{1'b0}};
      work_q  <= {(2*WIDTH){1'b0}};
      rem_q   <= {(WIDTH+1){1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      opa_q   <= opa_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status decode and HI/LO read mux; all forced low while reset is held.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    dataOut = {WIDTH{1'b0}};
    if (reset) begin
      busy    = 1'b0;
      done    = 1'b0;
      dataOut = {WIDTH{1'b0}};
    end else begin
      busy = (state_q == S_MUL) || (state_q == S_DIV);
      done = (state_q == S_DONE);
      case (Signal)
        MFHI:    dataOut = hi_q;
        MFLO:    dataOut = lo_q;
        default: dataOut = {WIDTH{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized
// MULTU/DIVU traffic compared against plain-arithmetic reference results.
module tb_mul_div_unit;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  mul_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact 64-bit product, or quotient/remainder with the divide-by-zero result.
  task automatic ref_model(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    if (sig == MULTU) begin
      p  = 64'(a) * 64'(b);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endtask

  // Present an op for one edge; returns #1 after that edge with start low.
  task automatic accept(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    Signal = sig;
    dataA  = a;
    dataB  = b;
    @(posedge clk); #1;
    start  = 1'b0;
    Signal = 6'd0;
  endtask

  // Count busy cycles until done is seen, bounded; leaves us inside the done cycle.
  task automatic wait_done(output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    Signal = MFHI; #1;
    check_eq({tag, "_hi"}, 64'(dataOut), 64'(hi));
    Signal = MFLO; #1;
    check_eq({tag, "_lo"}, 64'(dataOut), 64'(lo));
    Signal = 6'd0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    int nb, nd;
    logic [31:0] eh, el;
    ref_model(sig, a, b, eh, el);
    accept(sig, a, b);
    wait_done(nb, nd);
    check_eq({tag, "_busy"}, 64'(nb), 64'd32);
    check_eq({tag, "_done"}, 64'(nd), 64'd1);
    read_hilo(tag, eh, el);
  endtask

  initial begin
    int nb, nd, nb2;
    logic [5:0]  sig;
    logic [31:0] a, b;

    reset  = 1'b1;
    start  = 1'b0;
    Signal = MFHI;
    dataA  = 32'd0;
    dataB  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dout", 64'(dataOut), 64'd0);
    reset  = 1'b0;
    Signal = 6'd0;
    @(posedge clk); #1;
    read_hilo("rst", 32'd0, 32'd0);

    // Directed arithmetic cases.
    run_op("mul3x5", MULTU, 32'd3, 32'd5);
    @(posedge clk); #1;
    check_eq("mul3x5_done_pulse", 64'(done), 64'd0);
    check_eq("mul3x5_idle_busy", 64'(busy), 64'd0);
    run_op("mulmax", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div100_7", DIVU, 32'd100, 32'd7);
    run_op("div_by0", DIVU, 32'h1234_5678, 32'd0);
    @(posedge clk); #1;

    // A DIVU presented while busy is ignored.
    accept(MULTU, 32'd6, 32'd7);
    nb2    = 0;
    start  = 1'b1;
    Signal = DIVU;
    dataA  = 32'd9;
    dataB  = 32'd3;
    repeat (5) begin
      if (busy) nb2++;
      @(posedge clk); #1;
    end
    start  = 1'b0;
    Signal = 6'd0;
    wait_done(nb, nd);
    check_eq("ovl_busy", 64'(nb + nb2), 64'd32);
    check_eq("ovl_done", 64'(nd), 64'd1);
    read_hilo("ovl", 32'd0, 32'd42);

    // Back-to-back issue during the done cycle.
    accept(DIVU, 32'd9, 32'd3);
    check_eq("b2b_busy_rise", 64'(busy), 64'd1);
    check_eq("b2b_done_low", 64'(done), 64'd0);
    wait_done(nb, nd);
    check_eq("b2b_busy", 64'(nb + 1), 64'd32 + 64'd1);
    check_eq("b2b_done", 64'(nd), 64'd1);
    read_hilo("b2b", 32'd0, 32'd3);
    @(posedge clk); #1;

    // Randomized traffic, with occasional zero divisors and back-to-back issue.
    for (int i = 0; i < 24; i++) begin
      sig = ($urandom_range(0, 1) == 0) ? MULTU : DIVU;
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), sig, a, b);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check_eq($sformatf("rnd%0d_idle", i), 64'({busy, done}), 64'd0);
      end
    end
    @(posedge clk); #1;

    // Non-mul/div funct with start: nothing happens, HI/LO untouched.
    run_op("pre_add", MULTU, 32'hDEAD_BEEF, 32'h0000_1001);
    @(posedge clk); #1;
    start  = 1'b1;
    Signal = ADD;
    @(posedge clk); #1;
    start  = 1'b0;
    check_eq("add_busy", 64'(busy), 64'd0);
    check_eq("add_dout", 64'(dataOut), 64'd0);
    nd = 0;
    repeat (36) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    check_eq("add_nostate", 64'(nd), 64'd0);
    read_hilo("add", 32'h0000_0DEB, 32'hDEAD_BEEF * 32'h0000_1001);

    // Reset in the middle of an operation aborts it and clears HI/LO.
    accept(MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (10) @(posedge clk);
    #1;
    Signal = MFLO;
    reset  = 1'b1;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    check_eq("mid_rst_dout", 64'(dataOut), 64'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    Signal = 6'd0;
    read_hilo("mid_rst", 32'd0, 32'd0);
    nd = 0;
    repeat (40) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    check_eq("mid_rst_nodone", 64'(nd), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
